// File: rtl/parser_pkg.sv
// Shared types and default patterns for the frame parser.
package parser_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_BODY  = 2'd1,
        ST_TRAIL = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TRAILER = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_e;

    // First-received symbol sits in the most significant byte.
    localparam logic [31:0] DEF_HDR_PAT = 32'h11_11_11_11;
    localparam logic [31:0] DEF_TRL_PAT = 32'h00_11_00_11;

endpackage

// File: rtl/frame_pat_match.sv
// Valid-gated symbol history with fill count; flags when the newest LEN
// valid symbols (history plus the current one) equal PAT.
module frame_pat_match #(
    parameter int DW  = 8,
    parameter int LEN = 4,
    parameter logic [LEN*DW-1:0] PAT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data,
    input  logic          data_valid,
    output logic          match
);

    localparam int HL = (LEN > 1) ? LEN - 1 : 1;
    localparam int FW = $clog2(LEN + 1);

    // hist_q[0] is the most recent previous valid symbol.
    logic [HL-1:0][DW-1:0]  hist_q, hist_d;
    logic [LEN-1:0][DW-1:0] win_s;
    logic [FW-1:0]          fill_q, fill_d;

    // Shift history and saturating fill count on each valid symbol.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (data_valid) begin
            hist_d[0] = data;
            for (int i = 1; i < HL; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            fill_d = (fill_q == FW'(LEN)) ? fill_q : fill_q + FW'(1);
        end else begin
            hist_d = hist_q;
        end
    end

    // Compare window: current symbol last, oldest history symbol first.
    always_comb begin
        win_s[0] = data;
        for (int i = 1; i < LEN; i++) begin
            win_s[i] = hist_q[i-1];
        end
        match = data_valid && (win_s == PAT) && (fill_q >= FW'(LEN - 1));
    end

    // History registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/frame_parser.sv
// Header-synchronised fixed-length frame parser with one-deep output hold.
// Optional payload checksum enabled by defining PARSER_CSUM_EN.
module frame_parser
    import parser_pkg::*;
#(
    parameter int DW      = 8,
    parameter int HDR_LEN = 4,
    parameter int PAY_LEN = 12,
    parameter int TRL_LEN = 4,
    parameter logic [HDR_LEN*DW-1:0] HDR_PAT = DEF_HDR_PAT,
    parameter logic [TRL_LEN*DW-1:0] TRL_PAT = DEF_TRL_PAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DW-1:0]         data,
    input  logic                  data_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAY_LEN*DW-1:0] payload,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int CW = $clog2((PAY_LEN > TRL_LEN) ? PAY_LEN : TRL_LEN);
    localparam logic [TRL_LEN-1:0][DW-1:0] TRL_SYMS = TRL_PAT;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [PAY_LEN-1:0][DW-1:0] staging_q, staging_d, payload_q, payload_d;
    logic                     out_valid_q, out_valid_d;
    logic                     err_q, err_d;
    logic [1:0]               err_code_q, err_code_d;

    logic          hdr_match_s, trl_bad_s, frame_done_s, csum_ok_s;
    logic          commit_s, overrun_s;
    logic [DW-1:0] trl_exp_s;

    frame_pat_match #(.DW(DW), .LEN(HDR_LEN), .PAT(HDR_PAT)) u_hdr (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_valid (data_valid),
        .match      (hdr_match_s)
    );

    // Trailer and checksum evaluation on the current symbol.
    always_comb begin
        trl_exp_s = '0;
        for (int k = 0; k < TRL_LEN; k++) begin
            trl_exp_s = (cnt_q == CW'(k)) ? TRL_SYMS[TRL_LEN-1-k] : trl_exp_s;
        end
`ifdef PARSER_CSUM_EN
        begin
            logic [DW-1:0] x_s;
            x_s = '0;
            for (int k = 0; k < PAY_LEN - 1; k++) begin
                x_s = x_s ^ staging_q[k];
            end
            csum_ok_s = (x_s == staging_q[PAY_LEN-1]);
        end
`else
        csum_ok_s = 1'b1;
`endif
        trl_bad_s    = data_valid && (state_q == ST_TRAIL) && (data != trl_exp_s);
        frame_done_s = data_valid && (state_q == ST_TRAIL) && (data == trl_exp_s)
                       && (cnt_q == CW'(TRL_LEN - 1));
        commit_s     = frame_done_s && csum_ok_s && (!out_valid_q || out_ready);
        overrun_s    = frame_done_s && csum_ok_s && out_valid_q && !out_ready;
    end

    // Next-state logic; header matches are only honoured while hunting.
    always_comb begin
        case (state_q)
            ST_HUNT:  state_d = hdr_match_s ? ST_BODY : ST_HUNT;
            ST_BODY:  state_d = (data_valid && cnt_q == CW'(PAY_LEN - 1)) ? ST_TRAIL : ST_BODY;
            ST_TRAIL: state_d = (trl_bad_s || frame_done_s) ? ST_HUNT : ST_TRAIL;
            default:  state_d = ST_HUNT;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d     = cnt_q;
        staging_d = staging_q;
        case (state_q)
            ST_HUNT: cnt_d = '0;
            ST_BODY: begin
                if (data_valid) begin
                    for (int k = 0; k < PAY_LEN; k++) begin
                        staging_d[k] = (cnt_q == CW'(k)) ? data : staging_q[k];
                    end
                    cnt_d = (cnt_q == CW'(PAY_LEN - 1)) ? '0 : cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_TRAIL: begin
                if (data_valid) begin
                    cnt_d = (trl_bad_s || frame_done_s) ? '0 : cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = '0;
        endcase

        payload_d = commit_s ? staging_q : payload_q;
        if (commit_s) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        err_d = trl_bad_s || (frame_done_s && !csum_ok_s) || overrun_s;
        if (trl_bad_s) begin
            err_code_d = ERR_TRAILER;
        end else if (frame_done_s && !csum_ok_s) begin
            err_code_d = ERR_CSUM;
        end else if (overrun_s) begin
            err_code_d = ERR_OVERRUN;
        end else begin
            err_code_d = err_code_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            staging_q   <= '0;
            payload_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            cnt_q       <= cnt_d;
            staging_q   <= staging_d;
            payload_q   <= payload_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign payload   = payload_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_frame_parser.sv
// Randomised bench for frame_parser with a symbol-stream reference model
// and a few hand-computed frames that pin the model.
module tb_frame_parser;

    localparam int PAY_LEN = 12;
    localparam int TRL_LEN = 4;
`ifdef PARSER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        data_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, err;
    logic [95:0] payload;
    logic [1:0]  err_code;

    frame_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_valid (data_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .payload    (payload),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Reference model state
    logic [7:0] hdr_m [4] = '{8'h11, 8'h11, 8'h11, 8'h11};
    logic [7:0] trl_m [4] = '{8'h00, 8'h11, 8'h00, 8'h11};
    logic [7:0] hist_m [$];
    logic [7:0] buf_m [$];
    bit         in_frame_m;
    bit         m_ov, m_err;
    logic [1:0] m_code;
    logic [95:0] m_pay;
    logic [7:0] tx_q [$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist_m.delete();
        buf_m.delete();
        in_frame_m = 1'b0;
        m_ov = 1'b0;
        m_err = 1'b0;
        m_code = 2'd0;
        m_pay = '0;
    endtask

    task automatic model_step(input logic [7:0] d, input logic v, input logic rdy);
        bit e, commit, old_ov;
        logic [1:0] c;
        logic [7:0] x;
        int k;
        e = 1'b0; commit = 1'b0; c = 2'd0; old_ov = m_ov;
        if (v) begin
            if (in_frame_m) begin
                buf_m.push_back(d);
                if (buf_m.size() > PAY_LEN) begin
                    k = buf_m.size() - PAY_LEN - 1;
                    if (d != trl_m[k]) begin
                        e = 1'b1; c = 2'd1; in_frame_m = 1'b0;
                    end else if (k == TRL_LEN - 1) begin
                        in_frame_m = 1'b0;
                        x = 8'h00;
                        for (int i = 0; i < PAY_LEN - 1; i++) x = x ^ buf_m[i];
                        if (CSUM && x != buf_m[PAY_LEN-1]) begin
                            e = 1'b1; c = 2'd2;
                        end else if (!old_ov || rdy) begin
                            commit = 1'b1;
                        end else begin
                            e = 1'b1; c = 2'd3;
                        end
                    end
                end
            end else if (hist_m.size() == 3 && hist_m[0] == hdr_m[0] && hist_m[1] == hdr_m[1]
                         && hist_m[2] == hdr_m[2] && d == hdr_m[3]) begin
                in_frame_m = 1'b1;
                buf_m.delete();
            end
            hist_m.push_back(d);
            if (hist_m.size() > 3) void'(hist_m.pop_front());
        end
        if (commit) begin
            for (int i = 0; i < PAY_LEN; i++) m_pay[i*8 +: 8] = buf_m[i];
            m_ov = 1'b1;
        end else if (old_ov && rdy) begin
            m_ov = 1'b0;
        end
        m_err = e;
        if (e) m_code = c;
    endtask

    // Compare process: every cycle after the first reset
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("out_valid", {95'd0, out_valid}, {95'd0, m_ov});
            chk("err", {95'd0, err}, {95'd0, m_err});
            chk("err_code", {94'd0, err_code}, {94'd0, m_code});
            chk("payload", payload, m_pay);
        end
    end

    task automatic cyc(input logic [7:0] d, input logic v, input logic rdy);
        @(negedge clk);
        data = d; data_valid = v; out_ready = rdy;
        model_step(d, v, rdy);
        @(posedge clk);
        #2;
    endtask

    function automatic logic rdy_of(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(1));
    endfunction

    function automatic logic [95:0] csum_fix(input logic [95:0] p);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < PAY_LEN - 1; i++) x = x ^ p[i*8 +: 8];
        p[88 +: 8] = x;
        return p;
    endfunction

    task automatic q_frame(input logic [95:0] pay, input logic [31:0] trl);
        tx_q.push_back(8'h55);
        for (int i = 0; i < 4; i++) tx_q.push_back(8'h11);
        for (int i = 0; i < PAY_LEN; i++) tx_q.push_back(pay[i*8 +: 8]);
        for (int i = 0; i < TRL_LEN; i++) tx_q.push_back(trl[(3-i)*8 +: 8]);
    endtask

    task automatic flush(input int gap_pct, input int rdy_mode);
        while (tx_q.size() > 0) begin
            if (int'($urandom_range(99)) < gap_pct)
                cyc(8'($urandom), 1'b0, rdy_of(rdy_mode));
            else
                cyc(tx_q.pop_front(), 1'b1, rdy_of(rdy_mode));
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; data_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        #2;
        chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
        chk("rst_err", {95'd0, err}, 96'd0);
        chk("rst_err_code", {94'd0, err_code}, 96'd0);
        chk("rst_payload", payload, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [95:0] f1, f2, pay;
    logic [31:0] trl;

    initial begin
        f1 = 96'h32_30_30_41_2f_33_30_2f_33_32_30_32;
        f2 = 96'hc1_b2_a3_94_85_76_67_58_49_3a_2b_1c;
        if (CSUM) begin
            f1 = csum_fix(f1);
            f2 = csum_fix(f2);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        do_reset(2);

        // Clean frame, consumer always ready
        q_frame(f1, 32'h00110011);
        flush(0, 1);
        chk("good_out_valid", {95'd0, out_valid}, 96'd1);
        chk("good_payload", payload, f1);
        chk("good_err", {95'd0, err}, 96'd0);
        cyc(8'h00, 1'b0, 1'b1);
        chk("consumed", {95'd0, out_valid}, 96'd0);

        // Same frame with valid gaps
        q_frame(f1, 32'h00110011);
        flush(50, 1);
        chk("gap_out_valid", {95'd0, out_valid}, 96'd1);
        chk("gap_payload", payload, f1);
        cyc(8'h00, 1'b0, 1'b1);

        // Trailer 00 11 01 11: error on the third trailer symbol
        q_frame(f2, 32'h00110111);
        void'(tx_q.pop_back());
        flush(0, 1);
        chk("trl_err", {95'd0, err}, 96'd1);
        chk("trl_code", {94'd0, err_code}, 96'd1);
        cyc(8'h11, 1'b1, 1'b1);
        chk("trl_err_pulse", {95'd0, err}, 96'd0);
        chk("trl_code_hold", {94'd0, err_code}, 96'd1);
        chk("trl_no_commit", {95'd0, out_valid}, 96'd0);
        q_frame(f2, 32'h00110011);
        flush(0, 1);
        chk("after_trl_payload", payload, f2);
        cyc(8'h00, 1'b0, 1'b1);

        // Two frames with consumer stalled: second overruns
        q_frame(f1, 32'h00110011);
        q_frame(f2, 32'h00110011);
        flush(0, 0);
        chk("ovr_err", {95'd0, err}, 96'd1);
        chk("ovr_code", {94'd0, err_code}, 96'd3);
        chk("ovr_held", payload, f1);
        chk("ovr_valid", {95'd0, out_valid}, 96'd1);
        cyc(8'h00, 1'b0, 1'b1);

        // Reset after six payload bytes, then a full frame
        q_frame(f2, 32'h00110011);
        while (tx_q.size() > 11) void'(tx_q.pop_back());
        flush(0, 1);
        do_reset(2);
        q_frame(f1, 32'h00110011);
        flush(0, 1);
        chk("post_rst_payload", payload, f1);
        chk("post_rst_valid", {95'd0, out_valid}, 96'd1);
        cyc(8'h00, 1'b0, 1'b1);

`ifdef PARSER_CSUM_EN
        pay = f2;
        pay[88 +: 8] = f2[88 +: 8] ^ 8'hff;
        q_frame(pay, 32'h00110011);
        flush(0, 1);
        chk("csum_err", {95'd0, err}, 96'd1);
        chk("csum_code", {94'd0, err_code}, 96'd2);
        chk("csum_no_commit", {95'd0, out_valid}, 96'd0);
        q_frame(f2, 32'h00110011);
        flush(0, 1);
        chk("csum_ok_payload", payload, f2);
        cyc(8'h00, 1'b0, 1'b1);
`endif

        // Randomised stream of frames, corrupt trailers, noise and resets
        for (int seg = 0; seg < 160; seg++) begin
            int r;
            r = int'($urandom_range(10));
            for (int i = 0; i < 3; i++) pay[i*32 +: 32] = $urandom;
            if (CSUM && $urandom_range(3) != 0) pay = csum_fix(pay);
            if (r <= 5) begin
                q_frame(pay, 32'h00110011);
            end else if (r <= 7) begin
                trl = 32'h00110011 ^ (32'h1 << $urandom_range(31));
                q_frame(pay, trl);
            end else if (r <= 9) begin
                for (int i = 0; i < int'($urandom_range(8, 1)); i++) begin
                    case ($urandom_range(2))
                        0: tx_q.push_back(8'h11);
                        1: tx_q.push_back(8'h00);
                        default: tx_q.push_back(8'($urandom));
                    endcase
                end
            end else begin
                q_frame(pay, 32'h00110011);
                while (tx_q.size() > int'($urandom_range(19, 3))) void'(tx_q.pop_back());
                flush(30, 2);
                do_reset(int'($urandom_range(3, 1)));
            end
            flush(30, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_parser.md
FRAME_PARSER -- requirements
Module: frame_parser

Interface
REQ-001 Parameter DW, 8: width of one input symbol and of each payload element.
REQ-002 Parameter HDR_LEN, 4: header length in symbols.
REQ-003 Parameter PAY_LEN, 12: fixed payload length in symbols (>=2).
REQ-004 Parameter TRL_LEN, 4: trailer length in symbols.
REQ-005 Parameter HDR_PAT, {8'h11,8'h11,8'h11,8'h11}: header symbols, first-received first.
REQ-006 Parameter TRL_PAT, {8'h00,8'h11,8'h00,8'h11}: trailer symbols, first-received first.
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 data  in  DW  input symbol.
REQ-010 data_valid  in  1  data qualifier; symbols with data_valid=0 are ignored.
REQ-011 out_valid  out  1  payload held and valid.
REQ-012 out_ready  in  1  consumer accepts payload when out_valid&&out_ready.
REQ-013 payload  out  PAY_LEN x DW  last committed frame, payload[0] = first payload symbol.
REQ-014 err  out  1  one-cycle error pulse.
REQ-015 err_code  out  2  1=trailer mismatch, 2=checksum fail, 3=overrun; held until next err.

Function
REQ-016 FSM states HUNT, BODY, TRAIL; reset state HUNT.
REQ-017 HUNT: header history (last HDR_LEN valid symbols) updates on every valid symbol in every state; match = {history, data} equals HDR_PAT on a valid symbol, allowed only after >=HDR_LEN valid symbols since reset; match -> BODY next cycle, symbol count cleared.
REQ-018 BODY: each valid symbol writes staging[cnt], cnt+1; after symbol PAY_LEN-1 -> TRAIL, cnt cleared.
REQ-019 TRAIL: each valid symbol compared to TRL_PAT[cnt]; mismatch -> err=1, err_code=1, frame dropped, HUNT next cycle.
REQ-020 Last trailer symbol matching -> frame complete, HUNT next cycle.
REQ-021 Commit on completion: if out_valid=0 or out_ready=1 that cycle, payload<=staging and out_valid=1 the following cycle (latency 1 cycle after last trailer symbol).
REQ-022 Completion while out_valid=1 and out_ready=0: frame dropped, err=1, err_code=3, held payload unchanged.
REQ-023 out_valid&&out_ready with no simultaneous commit: out_valid=0 next cycle; payload stays stable while out_valid=1.
REQ-024 Header pattern inside BODY/TRAIL is payload data, never a resync.
REQ-025 err is high exactly one cycle per error event; err_code priority: 1 over 2 over 3.

Reset
REQ-026 rst_n low at any time, including mid-frame: state HUNT, cnt 0, history and fill count 0, staging and payload 0, out_valid 0, err 0, err_code 0; partial frame discarded.
REQ-027 First header is accepted only after HDR_LEN full valid symbols following reset release.

Configuration
REQ-028 With PARSER_CSUM_EN defined: payload[PAY_LEN-1] SHALL equal XOR of symbols 0..PAY_LEN-2; mismatch at completion -> err=1, err_code=2, no commit.
REQ-029 Without PARSER_CSUM_EN: no check, last payload symbol is plain data, err_code 2 never produced.

Structure
REQ-030 Package parser_pkg holds the state enum, err_code enum, default HDR_PAT/TRL_PAT constants.
REQ-031 Sub-module frame_pat_match: valid-gated shift history plus fill count plus compare, used for header detection.

Verification (defaults, no checksum unless noted)
REQ-032 11 11 11 11, bytes 32 30 32 33 2f 30 33 2f 41 30 30 32, 00 11 00 11 -> out_valid 1 cycle after last 11, payload = those 12 bytes, err=0.
REQ-033 Same frame with data_valid gaps between symbols -> identical payload, commit 1 cycle after last trailer symbol.
REQ-034 Trailer 00 11 01 11 -> err pulse, err_code=1, out_valid stays 0, next valid frame accepted.
REQ-035 Two good frames, out_ready=0 throughout -> first payload held, second dropped with err_code=3.
REQ-036 rst_n low after 6 payload bytes, then full good frame -> only second frame committed, outputs 0 during reset.
REQ-037 PARSER_CSUM_EN: last payload byte wrong (e.g. 00 instead of XOR) -> err_code=2, no commit; correct XOR -> commit.
